// File: rtl/reg_write_arb.sv
// reg_write_arb: round-robin ALU/load arbiter onto the single register-file write port.
// Optional forwarding ports and logic are built when REG_WRITE_ARB_FWD_EN is defined.
module reg_write_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  writeReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [15:0] wr_count
`ifdef REG_WRITE_ARB_FWD_EN
  ,
  input  logic [4:0]  fwd_reg1,
  input  logic [4:0]  fwd_reg2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
`endif
);
  // r_mem_pri set means the load side wins the next contended cycle
  logic        r_mem_pri;
  logic        w_go;
  logic        w_wr;
  logic [4:0]  w_reg;
  logic [31:0] w_data;
  always_comb begin
    alu_ready = !rst && !hold && alu_valid && (!mem_valid || !r_mem_pri);
    mem_ready = !rst && !hold && mem_valid && (!alu_valid || r_mem_pri);
    w_go      = alu_ready || mem_ready;
    w_reg     = mem_ready ? mem_reg : alu_reg;
    w_data    = mem_ready ? mem_data : alu_data;
    w_wr      = w_go && (w_reg != 5'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_pri <= 1'b0;
      writeReg  <= '0;
      WriteData <= '0;
      RegWrite  <= 1'b0;
      wr_count  <= '0;
    end else begin
      RegWrite <= w_wr;
      if (w_go) begin
        writeReg  <= w_reg;
        WriteData <= w_data;
        r_mem_pri <= alu_ready;
      end
      if (w_wr) wr_count <= wr_count + 16'd1;
    end
  end
`ifdef REG_WRITE_ARB_FWD_EN
  always_comb begin
    fwd_hit1  = RegWrite && (fwd_reg1 == writeReg) && (fwd_reg1 != 5'd0);
    fwd_hit2  = RegWrite && (fwd_reg2 == writeReg) && (fwd_reg2 != 5'd0);
    fwd_data1 = fwd_hit1 ? WriteData : 32'd0;
    fwd_data2 = fwd_hit2 ? WriteData : 32'd0;
  end
`endif
endmodule
